// File: rtl/matrix_write_arbiter.sv
// matrix_write_arbiter
//   Shares the single matrix-memory write port between num_req_p requesters
//   (commit executor, line-clear executor, board-clear sequencer). One 4x4
//   block write is in flight at a time. Requesters are granted round-robin.
//   Each accepted write issues a one-cycle strobe and waits for the memory to
//   report ready. It then pulses a done strobe to the requester that owns it.
//
//   Block origins (point_t) are packed as {x, y}. x uses $clog2(width_p)
//   bits in the upper field and y uses $clog2(height_p) bits in the lower
//   field.
//
// Ports
//   clk_i            clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   req_v_i          per-requester write request, held until accepted
//   req_addr_i       per-requester 4x4 block origin
//   req_data_i       per-requester 4x4 cell data
//   req_ready_o      one-hot acceptance strobe (combinational, idle only)
//   req_done_o       one-hot completion pulse to the owner of the write
//   busy_o           high whenever a write is in flight
//   mm_write_addr_o  latched block origin towards matrix memory
//   mm_write_data_o  latched cell data towards matrix memory
//   mm_write_v_o     one-cycle write strobe
//   mm_is_ready_i    memory has finished the last write
module matrix_write_arbiter #(
  parameter int num_req_p = 3,
  parameter int width_p   = 16,
  parameter int height_p  = 32,
  localparam int idx_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int cand_w_lp = idx_w_lp + 1,
  localparam int x_w_lp    = $clog2(width_p),
  localparam int y_w_lp    = $clog2(height_p),
  localparam int addr_w_lp = x_w_lp + y_w_lp
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  input  logic [num_req_p-1:0][addr_w_lp-1:0]   req_addr_i,
  input  logic [num_req_p-1:0][3:0][3:0]        req_data_i,
  output logic [num_req_p-1:0]                  req_ready_o,
  output logic [num_req_p-1:0]                  req_done_o,
  output logic                                  busy_o,
  output logic [addr_w_lp-1:0]                  mm_write_addr_o,
  output logic [3:0][3:0]                       mm_write_data_o,
  output logic                                  mm_write_v_o,
  input  logic                                  mm_is_ready_i
);

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2,
    eDone  = 2'd3
  } state_e;

  state_e                 state_r;
  state_e                 state_next_s;
  logic [idx_w_lp-1:0]    rr_ptr_r;
  logic [idx_w_lp-1:0]    rr_ptr_next_s;
  logic [idx_w_lp-1:0]    owner_r;
  logic [addr_w_lp-1:0]   addr_r;
  logic [3:0][3:0]        data_r;

  logic                   found_s;
  logic [idx_w_lp-1:0]    winner_s;
  logic [cand_w_lp-1:0]   cand_s;
  logic [num_req_p-1:0]   grant_s;
  logic                   accept_s;

  logic                   busy_r;
  logic                   write_v_r;
  logic [num_req_p-1:0]   done_r;
  logic                   busy_next_s;
  logic                   write_v_next_s;
  logic [num_req_p-1:0]   done_next_s;

  // Round-robin search upward from rr_ptr_r, wrapping modulo num_req_p.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand_s = {1'b0, rr_ptr_r} + cand_w_lp'(k);
      if (cand_s >= cand_w_lp'(num_req_p)) begin
        cand_s = cand_s - cand_w_lp'(num_req_p);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_v_i[cand_s[idx_w_lp-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_s[idx_w_lp-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot grant vector and acceptance qualifier (arbitration only in idle).
  always_comb begin
    grant_s = '0;
    if (found_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    accept_s = (state_r == eIDLE) && found_s;
  end

  // Pointer moves just past the winner, wrapping after the last requester.
  always_comb begin
    if (winner_s == idx_w_lp'(num_req_p - 1)) begin
      rr_ptr_next_s = '0;
    end else begin
      rr_ptr_next_s = winner_s + idx_w_lp'(1);
    end
  end

  // Acceptance strobe; gated by reset so it is 0 while reset is held.
  always_comb begin
    if ((state_r == eIDLE) && reset_n_i) begin
      req_ready_o = grant_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      eIDLE: begin
        if (found_s) begin
          state_next_s = eIssue;
        end else begin
          state_next_s = eIDLE;
        end
      end
      eIssue: state_next_s = eWait;
      eWait: begin
        if (mm_is_ready_i) begin
          state_next_s = eDone;
        end else begin
          state_next_s = eWait;
        end
      end
      eDone:   state_next_s = eIDLE;
      default: state_next_s = eIDLE;
    endcase
  end

  // Output decode from the next state so the strobes are driven by flops.
  always_comb begin
    busy_next_s    = (state_next_s != eIDLE);
    write_v_next_s = (state_next_s == eIssue);
    done_next_s    = '0;
    if (state_next_s == eDone) begin
      done_next_s[owner_r] = 1'b1;
    end else begin
      done_next_s = '0;
    end
  end

  // Registered status and strobe outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_r    <= 1'b0;
      write_v_r <= 1'b0;
      done_r    <= '0;
    end else begin
      busy_r    <= busy_next_s;
      write_v_r <= write_v_next_s;
      done_r    <= done_next_s;
    end
  end

  // Capture the winner's request and advance the pointer on acceptance.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= '0;
      owner_r  <= '0;
      addr_r   <= '0;
      data_r   <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= rr_ptr_next_s;
      owner_r  <= winner_s;
      addr_r   <= req_addr_i[winner_s];
      data_r   <= req_data_i[winner_s];
    end
  end

  assign busy_o          = busy_r;
  assign mm_write_v_o    = write_v_r;
  assign req_done_o      = done_r;
  assign mm_write_addr_o = addr_r;
  assign mm_write_data_o = data_r;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
module tb_matrix_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 9;

  logic                    clk = 1'b0;
  logic                    reset_n_i;
  logic [NR-1:0]           req_v_i;
  logic [NR-1:0][AW-1:0]   req_addr_i;
  logic [NR-1:0][3:0][3:0] req_data_i;
  logic [NR-1:0]           req_ready_o;
  logic [NR-1:0]           req_done_o;
  logic                    busy_o;
  logic [AW-1:0]           mm_write_addr_o;
  logic [3:0][3:0]         mm_write_data_o;
  logic                    mm_write_v_o;
  logic                    mm_is_ready_i;

  // requester side of the bench
  logic [NR-1:0]           pend;
  logic [NR-1:0][AW-1:0]   r_addr;
  logic [NR-1:0][15:0]     r_data;
  assign req_v_i    = pend;
  assign req_addr_i = r_addr;
  assign req_data_i = r_data;

  matrix_write_arbiter #(.num_req_p(NR), .width_p(16), .height_p(32)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .req_v_i        (req_v_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .req_done_o     (req_done_o),
    .busy_o         (busy_o),
    .mm_write_addr_o(mm_write_addr_o),
    .mm_write_data_o(mm_write_data_o),
    .mm_write_v_o   (mm_write_v_o),
    .mm_is_ready_i  (mm_is_ready_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: one transaction in flight, described by its age.
  bit            chk_en = 1'b0;
  bit            m_active;
  bit            m_done_now;
  int            m_age;
  int            m_ptr;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_data;
  logic [NR-1:0] grant_evt;
  int            grant_log[$];
  logic [NR-1:0] exp_ready;
  logic [NR-1:0] exp_done;
  int            w;

  function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Compare process: check every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    grant_evt = '0;
    if (chk_en) begin
      if (!reset_n_i) begin
        m_active = 1'b0; m_done_now = 1'b0; m_age = 0; m_ptr = 0; m_owner = 0;
        m_addr = '0; m_data = '0;
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_done", 32'(req_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_strobe", 32'(mm_write_v_o), 32'd0);
        chk("rst_addr", 32'(mm_write_addr_o), 32'd0);
        chk("rst_data", 32'(mm_write_data_o), 32'd0);
      end else begin
        w = rr_pick(req_v_i, m_ptr);
        exp_ready = '0;
        if (!m_active && w >= 0) exp_ready[w] = 1'b1;
        exp_done = '0;
        if (m_done_now) exp_done[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
        chk("req_done", 32'(req_done_o), 32'(exp_done));
        chk("busy", 32'(busy_o), 32'(m_active));
        chk("mm_write_v", 32'(mm_write_v_o), 32'(m_active && m_age == 1));
        chk("mm_addr", 32'(mm_write_addr_o), 32'(m_addr));
        chk("mm_data", 32'(mm_write_data_o), 32'(m_data));
        if (!m_active) begin
          if (w >= 0) begin
            m_active = 1'b1; m_age = 1; m_owner = w;
            m_addr = req_addr_i[w]; m_data = req_data_i[w];
            m_ptr = (w + 1) % NR;
            grant_evt[w] = 1'b1;
            grant_log.push_back(w);
          end
        end else if (m_done_now) begin
          m_active = 1'b0; m_done_now = 1'b0;
        end else begin
          if (m_age >= 2 && mm_is_ready_i) m_done_now = 1'b1;
          m_age++;
        end
      end
    end
  end

  // Advance one cycle; a requester that was granted drops its request.
  task automatic next_cyc();
    @(posedge clk); #1;
    pend = pend & ~grant_evt;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    r_addr[i] = AW'($urandom);
    r_data[i] = 16'($urandom);
  endtask

  // Assert reset (outputs must drop at once), hold n cycles, release.
  task automatic do_reset(input int n);
    reset_n_i = 1'b0;
    pend = '0;
    #1;
    chk("rst_now_busy", 32'(busy_o), 32'd0);
    chk("rst_now_strobe", 32'(mm_write_v_o), 32'd0);
    chk("rst_now_done", 32'(req_done_o), 32'd0);
    chk("rst_now_ready", 32'(req_ready_o), 32'd0);
    repeat (n) next_cyc();
    reset_n_i = 1'b1;
  endtask

  task automatic wait_quiet(input int max);
    int k;
    k = 0;
    mm_is_ready_i = 1'b1;
    while ((m_active || pend != '0) && k < max) begin
      next_cyc();
      k++;
    end
    chk("quiet_timeout", 32'(k < max), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int strobes;
    reset_n_i = 1'b0; pend = '0; r_addr = '0; r_data = '0; mm_is_ready_i = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n_i = 1'b1;

    // idle after reset
    repeat (10) next_cyc();
    at_neg();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // single request from requester 1
    next_cyc();
    mm_is_ready_i = 1'b1;
    r_addr[1] = {4'd5, 5'd10};
    r_data[1] = 16'h0660;
    pend[1]   = 1'b1;
    at_neg();
    chk("t2_ready", 32'(req_ready_o), 32'h2);
    next_cyc(); at_neg();
    chk("t2_strobe", 32'(mm_write_v_o), 32'd1);
    chk("t2_addr", 32'(mm_write_addr_o), 32'h0AA);
    chk("t2_data", 32'(mm_write_data_o), 32'h0660);
    next_cyc(); next_cyc(); at_neg();
    chk("t2_done", 32'(req_done_o), 32'h2);
    next_cyc();
    wait_quiet(20);

    // contention: all three valid from reset
    do_reset(2);
    start = grant_log.size();
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = AW'(i + 1);
      r_data[i] = 16'hA000 + 16'(i);
    end
    pend = '1;
    repeat (14) begin
      next_cyc();
      pend = '1;
    end
    chk("t3_ngrants", 32'(grant_log.size() - start >= 4), 32'd1);
    if (grant_log.size() - start >= 4) begin
      chk("t3_grant0", 32'(grant_log[start]), 32'd0);
      chk("t3_grant1", 32'(grant_log[start + 1]), 32'd1);
      chk("t3_grant2", 32'(grant_log[start + 2]), 32'd2);
      chk("t3_grant3", 32'(grant_log[start + 3]), 32'd0);
    end
    pend = '0;
    wait_quiet(20);

    // memory stall of 6 cycles after the strobe
    do_reset(2);
    mm_is_ready_i = 1'b0;
    r_addr[0] = 9'h123; r_data[0] = 16'h1234; pend[0] = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cyc();
      if (c == 2) new_req(1);
      if (c == 8) mm_is_ready_i = 1'b1;
      at_neg();
      if (mm_write_v_o) strobes++;
      if (c >= 2 && c <= 8) chk("t4_no_ready", 32'(req_ready_o), 32'd0);
      if (c == 9) chk("t4_done", 32'(req_done_o), 32'h1);
      if (c == 10) chk("t4_next_grant", 32'(req_ready_o), 32'h2);
    end
    chk("t4_strobes", 32'(strobes), 32'd1);
    wait_quiet(20);

    // reset in the middle of a write
    do_reset(2);
    mm_is_ready_i = 1'b0;
    new_req(0);
    next_cyc(); next_cyc(); next_cyc();
    do_reset(2);
    new_req(2);
    at_neg();
    chk("t5_grant2", 32'(req_ready_o), 32'h4);
    wait_quiet(20);

    // wrap-around from pointer 2
    do_reset(2);
    mm_is_ready_i = 1'b1;
    new_req(1);
    wait_quiet(20);
    start = grant_log.size();
    new_req(0); new_req(2);
    wait_quiet(40);
    chk("t6_ngrants", 32'(grant_log.size() - start), 32'd2);
    if (grant_log.size() - start >= 2) begin
      chk("t6_first", 32'(grant_log[start]), 32'd2);
      chk("t6_second", 32'(grant_log[start + 1]), 32'd0);
    end
    new_req(0); new_req(1); new_req(2);
    at_neg();
    chk("t6_ptr1", 32'(req_ready_o), 32'h2);
    wait_quiet(40);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      next_cyc();
      if ($urandom_range(599) == 0) begin
        do_reset(1 + int'($urandom_range(1)));
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) new_req(i);
      end
      mm_is_ready_i = ($urandom_range(2) != 0);
    end
    wait_quiet(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
